// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side blocks.
// The burst reader FSM encoding is exported here so checkers can decode the debug state.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_DW    = 8;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus the downstream byte stream, bundled for the burst reader.
// Stream handshake: a byte moves when out_valid && out_ready at a rising edge; once out_valid is
// high, out_valid and out_data hold until that transfer happens.
interface fifo_burst_reader_if #(
  parameter int DW = 8
);

  logic          fifo_rden;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output fifo_rden,
    input  fifo_data,
    input  fifo_empty,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  fifo_rden,
    output fifo_data,
    output fifo_empty,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer between the FIFO read data and the output stream.
// Push and pop in the same cycle are allowed; head_data is always a registered entry.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [SKID_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // Guards keep the pointers sane even if a caller over- or under-runs.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the 32x8 FIFO: drains a programmed byte count and re-presents it on a
// valid/ready stream, issuing reads only when the skid buffer is guaranteed room.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DW        = FIFO_DW,
  parameter int LEN_W     = 6,
  parameter int BUF_DEPTH = SKID_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_reader_if.master bus,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    rd_count,
  output rd_state_t           state
);

  localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

  logic [LEN_W-1:0] remaining;
  logic             inflight;
  logic [1:0]       buf_count;
  logic [DW-1:0]    head;
  logic             has_data;
  logic             pop;
  logic             rden;
  logic [2:0]       occ_after_pop;

  assign has_data = (buf_count != 2'd0);
  assign pop      = has_data && bus.out_ready;

  // A read is safe if the entry it will land in is free by the time the data arrives:
  // bytes held plus the one in flight, minus any leaving this cycle, must leave a slot.
  assign occ_after_pop = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign rden = (state == READ) && !bus.fifo_empty && (remaining != '0) &&
                (occ_after_pop < CREDIT);

  assign bus.fifo_rden = rden;
  assign bus.out_valid = has_data;
  assign bus.out_data  = head;

  fifo_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head_data (head),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      rd_count  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rden;
      done     <= 1'b0;
      if (pop) begin
        rd_count <= rd_count + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            rd_count <= '0;
            if (len != '0) begin
              remaining <= len;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          if (rden) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Wait for the last in-flight byte to land and for the consumer to take everything.
          if (!inflight && !has_data) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural FIFO with 1-cycle read latency feeds the DUT,
// a table of bursts plus hand-written sequences cover stalls, empty gaps, ignored starts and reset.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] rd_count;
  rd_state_t        state;

  fifo_burst_reader_if #(.DW(DW)) bus ();

  fifo_burst_reader #(
    .DW(DW),
    .LEN_W(LEN_W),
    .BUF_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd_count (rd_count),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LEN_W-1:0] len;
    int               n_pre;
    logic [7:0]       base;
    logic [7:0]       step;
    int               stall;
    int               exp_cnt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int cyc = 0;
  int rden_cnt, done_cnt, busy_seen;
  int first_rden, last_rden, first_xfer, last_xfer, first_valid;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    rden_cnt    = 0;
    done_cnt    = 0;
    busy_seen   = 0;
    first_rden  = -1;
    last_rden   = -1;
    first_xfer  = -1;
    last_xfer   = -1;
    first_valid = -1;
  endtask

  // Behavioural FIFO: data appears the cycle after rden, empty updates on the clock.
  initial begin
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      if (bus.fifo_rden && fifo_q.size() > 0) begin
        bus.fifo_data <= fifo_q.pop_front();
      end
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic [DW-1:0] exp_b;
    clear_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (bus.fifo_rden) begin
          rden_cnt++;
          if (first_rden < 0) first_rden = cyc;
          last_rden = cyc;
          check("rden_while_empty", 32'(bus.fifo_empty), 32'd0);
        end
        if (busy) busy_seen = 1;
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
          done_cnt++;
          check("busy_in_done", 32'(busy), 32'd0);
        end
        if (hold_pending) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_data", 32'(bus.out_data), 32'(hold_data));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_byte: got 0x%0h, expected no transfer", bus.out_data);
          end else begin
            exp_b = exp_q.pop_front();
            check("out_data", 32'(bus.out_data), 32'(exp_b));
          end
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        hold_data    = bus.out_data;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    fifo_q.delete();
    exp_q.delete();
    tick();
  endtask

  task automatic wait_done(input string tag);
    int cycles = 0;
    while (done_cnt == 0 && cycles < 300) begin
      tick();
      cycles++;
    end
    repeat (3) tick();
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    logic [7:0] b;
    int         stall_cnt = 0;
    int         cycles = 0;
    logic       released;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.n_pre; i++) begin
      b = v.base + 8'(i) * v.step;
      fifo_q.push_back(b);
      if (i < int'(v.len)) exp_q.push_back(b);
    end
    tick();
    clear_stats();
    start         = 1'b1;
    len           = v.len;
    bus.out_ready = (v.stall == 0);
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'(v.len != '0));
    if (v.len == '0) check({tag, "_done_next_cycle"}, 32'(done), 32'd1);
    released = (v.stall == 0);
    while (done_cnt == 0 && cycles < 300) begin
      if (!released && bus.out_valid) begin
        if (stall_cnt == v.stall) begin
          check({tag, "_rden_before_release_le2"}, 32'(rden_cnt <= 2), 32'd1);
          bus.out_ready = 1'b1;
          released      = 1'b1;
        end else begin
          stall_cnt++;
        end
      end
      tick();
      cycles++;
    end
    repeat (3) tick();
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_rd_count"}, 32'(rd_count), 32'(v.exp_cnt));
    check({tag, "_rden_count"}, 32'(rden_cnt), 32'(v.exp_cnt));
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_state_idle"}, 32'(state), 32'(IDLE));
    if (v.len == '0) check({tag, "_busy_never"}, 32'(busy_seen), 32'd0);
    if (v.exp_cnt > 0) begin
      check({tag, "_first_valid_lat"}, 32'(first_valid - first_rden), 32'd2);
      if (v.stall == 0) begin
        check({tag, "_rden_back_to_back"}, 32'(last_rden - first_rden), 32'(v.exp_cnt - 1));
        check({tag, "_out_back_to_back"}, 32'(last_xfer - first_xfer), 32'(v.exp_cnt - 1));
      end
    end
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[5];
    vec_t post;
    int   cycles;

    tbl[0] = '{len: 6'd4, n_pre: 4, base: 8'h11, step: 8'h11, stall: 0, exp_cnt: 4};
    tbl[1] = '{len: 6'd4, n_pre: 4, base: 8'h11, step: 8'h11, stall: 5, exp_cnt: 4};
    tbl[2] = '{len: 6'd0, n_pre: 0, base: 8'h00, step: 8'h00, stall: 0, exp_cnt: 0};
    tbl[3] = '{len: 6'd1, n_pre: 1, base: 8'hC3, step: 8'h01, stall: 0, exp_cnt: 1};
    tbl[4] = '{len: 6'd7, n_pre: 9, base: 8'h80, step: 8'h05, stall: 2, exp_cnt: 7};

    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rden", 32'(bus.fifo_rden), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_burst(tbl[i], $sformatf("vec%0d", i));
    end

    // Empty FIFO: bytes trickle in with gaps, busy must stay up throughout.
    flush();
    clear_stats();
    bus.out_ready = 1'b1;
    start = 1'b1;
    len   = 6'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        tick();
        check("gap_busy", 32'(busy), 32'd1);
      end
      fifo_q.push_back(8'hA0 + 8'(k));
      exp_q.push_back(8'hA0 + 8'(k));
    end
    wait_done("gap");
    check("gap_rd_count", 32'(rd_count), 32'd3);
    check("gap_rden_count", 32'(rden_cnt), 32'd3);
    check("gap_bytes_left", 32'(exp_q.size()), 32'd0);

    // Second start while busy is ignored.
    flush();
    for (int k = 0; k < 4; k++) fifo_q.push_back(8'h51 + 8'(k));
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    tick();
    clear_stats();
    start = 1'b1;
    len   = 6'd2;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    len   = 6'd3;
    tick();
    start = 1'b0;
    wait_done("restart");
    repeat (4) tick();
    check("restart_done_total", 32'(done_cnt), 32'd1);
    check("restart_rden_count", 32'(rden_cnt), 32'd2);
    check("restart_rd_count", 32'(rd_count), 32'd2);
    check("restart_bytes_left", 32'(exp_q.size()), 32'd0);

    // Reset after two of six bytes have gone downstream.
    flush();
    for (int k = 0; k < 6; k++) fifo_q.push_back(8'h61 + 8'(k));
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    tick();
    clear_stats();
    bus.out_ready = 1'b1;
    start = 1'b1;
    len   = 6'd6;
    tick();
    start = 1'b0;
    cycles = 0;
    while (rd_count < 6'd2 && cycles < 50) begin
      tick();
      cycles++;
    end
    check("midrst_reached_two", 32'(rd_count), 32'd2);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rden", 32'(bus.fifo_rden), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_rd_count", 32'(rd_count), 32'd0);
    check("midrst_state", 32'(state), 32'(IDLE));
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_bytes_left", 32'(exp_q.size()), 32'd0);

    post = '{len: 6'd2, n_pre: 2, base: 8'h71, step: 8'h01, stall: 0, exp_cnt: 2};
    run_burst(post, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
